// File: rtl/rule30_decryptor.sv
// Stream decryptor: XORs each accepted byte with a Rule 30 keystream restarted on every sync,
// and buffers the plaintext in a 2-entry output FIFO.
module rule30_decryptor #(
  parameter logic [7:0] SEED = 8'b00011000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sync,
  input  logic [7:0] frame_len,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic [7:0] key,
  output logic       busy,
  output logic [8:0] byte_cnt
);

  localparam int DATA_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   key_q;
  logic [8:0]          cnt_q;
  logic [8:0]          len_q;
  logic [1:0]          occ_q;
  logic [DATA_W-1:0]   dec_p0;
  logic [DATA_W-1:0]   head_p1;
  logic [DATA_W-1:0]   tail_p1;
  logic                fifo_full;
  logic                accept;
  logic                pop;
  logic                last_byte;

  // One Rule 30 generation on a ring: new[i] = left ^ (center | right).
  function automatic logic [DATA_W-1:0] rule30_step(input logic [DATA_W-1:0] k);
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
    left  = {k[DATA_W-2:0], k[DATA_W-1]};
    right = {k[0], k[DATA_W-1:1]};
    return left ^ (k | right);
  endfunction

  assign fifo_full = (occ_q == 2'd2);
  assign in_ready  = (state == ACTIVE) && !sync && !fifo_full;
  assign accept    = in_valid && in_ready;
  assign out_valid = (occ_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign last_byte = ((cnt_q + 9'd1) == len_q);
  assign dec_p0    = in_data ^ key_q;

  assign out_data  = head_p1;
  assign key       = key_q;
  assign busy      = (state == ACTIVE);
  assign byte_cnt  = cnt_q;

  always_comb begin
    state_nxt = state;
    if (sync) begin
      state_nxt = ACTIVE;
    end else if ((state == ACTIVE) && accept && last_byte) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Keystream and frame bookkeeping; sync wins over accept (in_ready is low during sync).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q <= SEED;
      cnt_q <= 9'd0;
      len_q <= 9'd0;
    end else if (sync) begin
      key_q <= SEED;
      cnt_q <= 9'd0;
      len_q <= (frame_len == 8'd0) ? 9'd256 : {1'b0, frame_len};
    end else if (accept) begin
      key_q <= rule30_step(key_q);
      cnt_q <= cnt_q + 9'd1;
    end
  end

  // p0 -> p1: decrypted byte enters the output FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q   <= 2'd0;
      head_p1 <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
      // A push into an empty FIFO, or a push that coincides with the pop of the only entry,
      // lands directly at the head.
      if (accept && ((occ_q == 2'd0) || pop)) begin
        head_p1 <= dec_p0;
      end else if (pop && (occ_q == 2'd2)) begin
        head_p1 <= tail_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && (occ_q == 2'd1) && !pop) begin
      tail_p1 <= dec_p0;
    end
  end

endmodule

// File: doc/rule30_decryptor.md
RULE30_DECRYPTOR -- requirements
Module: rule30_decryptor

Interface
REQ-001 SHALL have parameter SEED, default 8'b00011000, initial keystream key loaded at reset and on every sync.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port sync  input  1  one-cycle pulse; starts a new frame and reloads the key to SEED.
REQ-005 SHALL have port frame_len  input  8  bytes per frame, sampled when sync is high; 0 means 256.
REQ-006 SHALL have port in_valid  input  1  encrypted byte present on in_data.
REQ-007 SHALL have port in_data  input  8  encrypted byte.
REQ-008 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-009 SHALL have port out_valid  output  1  decrypted byte present on out_data.
REQ-010 SHALL have port out_data  output  8  decrypted byte.
REQ-011 SHALL have port out_ready  input  1  consumer takes out_data this cycle.
REQ-012 SHALL have port key  output  8  key applied to the next accepted byte.
REQ-013 SHALL have port busy  output  1  high while state is ACTIVE.
REQ-014 SHALL have port byte_cnt  output  9  bytes accepted in the current frame.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and ACTIVE.
REQ-016 IDLE -> ACTIVE SHALL occur on sync; key <= SEED, byte_cnt <= 0, frame_len latched.
REQ-017 ACTIVE -> IDLE SHALL occur on the accept that makes byte_cnt equal the latched length.
REQ-018 sync in ACTIVE SHALL restart the frame as in REQ-016; bytes still queued in the output FIFO are kept.
REQ-019 in_ready SHALL be (state==ACTIVE) && !sync && FIFO not full; it is combinational from registered state only, with no path from in_valid.
REQ-020 Accept SHALL be in_valid && in_ready; on accept, push (in_data ^ key) into the FIFO and increment byte_cnt.
REQ-021 On accept, key SHALL advance by Rule 30 on a circular 8-bit ring: key[i] <= key[i-1] ^ (key[i] | key[i+1]), indices mod 8.
REQ-022 key SHALL hold its value in any cycle without an accept.
REQ-023 The output FIFO SHALL have 2 entries, first in first out; out_valid = FIFO not empty; out_data = head entry.
REQ-024 Pop SHALL be out_valid && out_ready; simultaneous push and pop on a full FIFO SHALL NOT occur, because in_ready is low when full.
REQ-025 Simultaneous push and pop on a 1-entry FIFO SHALL leave occupancy at 1 with the new byte at the head.
REQ-026 Latency SHALL be 1 cycle: a byte accepted at edge N drives out_valid high after edge N.
REQ-027 With out_ready held high, throughput SHALL be 1 byte per cycle.
REQ-028 out_data and out_valid SHALL stay stable while out_valid && !out_ready.
REQ-029 Keystream order SHALL be SEED, then 8'h2C, then 8'h66, and so on, for SEED = 8'b00011000.

Reset
REQ-030 rst high SHALL immediately clear: state = IDLE, key = SEED, byte_cnt = 0, FIFO empty, out_valid = 0, out_data = 0, in_ready = 0, busy = 0.
REQ-031 rst asserted mid-frame SHALL discard queued bytes; after release the block waits in IDLE for sync.

Verification
REQ-032 Reset, then sync with frame_len = 3, in_data = 0x18, 0x2C, 0x66 back-to-back with out_ready = 1 -> out_data 0x00, 0x00, 0x00 on consecutive cycles; busy falls after the 3rd accept.
REQ-033 Frame with frame_len = 1, in_data = 0xFF -> out_data = 0xE7, key = 0x2C afterwards, state IDLE.
REQ-034 out_ready = 0 while streaming -> in_ready drops after 2 accepts, out_data holds; raising out_ready drains in order with no loss.
REQ-035 sync mid-frame after 2 bytes -> key returns to 0x18, byte_cnt = 0, the 2 queued bytes are still delivered.
REQ-036 rst pulse while FIFO holds 2 bytes -> out_valid = 0 immediately; in_valid is ignored until the next sync.
REQ-037 frame_len = 0 -> exactly 256 accepts before busy falls; byte_cnt reaches 256.
